time_set_ctrl: RTL and testbench

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

---
 rtl/time_set_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: set-mode controller for an HH:MM:SS clock.
// Captures the live time into shadow registers, lets the user edit one field
// at a time with up/down buttons (single steps plus auto-repeat), and hands
// the edited value back to the counter datapath with a one-cycle load pulse.
module time_set_ctrl #(
  parameter int unsigned HOUR_MAX   = 24,
  parameter int unsigned MIN_MAX    = 60,
  parameter int unsigned SEC_MAX    = 60,
  parameter int unsigned REPEAT_DLY = 50_000_000,
  parameter int unsigned REPEAT_PER = 10_000_000,
  parameter int unsigned BLINK_PER  = 25_000_000,
  parameter int unsigned TIMEOUT    = 1_000_000_000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_btn_mode,
  input  logic                        i_btn_sel,
  input  logic                        i_btn_up,
  input  logic                        i_btn_down,
  input  logic [$clog2(HOUR_MAX)-1:0] i_hour,
  input  logic [$clog2(MIN_MAX)-1:0]  i_min,
  input  logic [$clog2(SEC_MAX)-1:0]  i_sec,
  output logic                        o_set_mode,
  output logic                        o_load,
  output logic [$clog2(HOUR_MAX)-1:0] o_hour,
  output logic [$clog2(MIN_MAX)-1:0]  o_min,
  output logic [$clog2(SEC_MAX)-1:0]  o_sec,
  output logic [1:0]                  o_cursor,
  output logic                        o_blink
);

  localparam int unsigned HW = $clog2(HOUR_MAX);
  localparam int unsigned MW = $clog2(MIN_MAX);
  localparam int unsigned SW = $clog2(SEC_MAX);
  localparam int unsigned RW = (REPEAT_DLY > 1) ? $clog2(REPEAT_DLY) : 1;
  localparam int unsigned BW = (BLINK_PER > 1) ? $clog2(BLINK_PER) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, SET_HOUR, SET_MIN, SET_SEC} state_t;

  state_t        state, state_n;
  logic [HW-1:0] hour_n;
  logic [MW-1:0] min_n;
  logic [SW-1:0] sec_n;
  logic [RW-1:0] hold_q, hold_n;
  logic [BW-1:0] bcnt_q, bcnt_n;
  logic [TW-1:0] to_q, to_n;
  logic [1:0]    cursor_n;
  logic          up_prev, dn_prev;
  logic          load_n, blink_n, fresh;
  logic          one_held, btn_edge, repeat_hit, step_up, step_dn;

  // Next-state, shadow arithmetic and the hold/blink/timeout counters
  always_comb begin
    state_n  = state;
    hour_n   = o_hour;
    min_n    = o_min;
    sec_n    = o_sec;
    hold_n   = hold_q;
    bcnt_n   = bcnt_q;
    blink_n  = o_blink;
    to_n     = to_q;
    load_n   = 1'b0;
    fresh    = 1'b0;
    step_up  = 1'b0;
    step_dn  = 1'b0;
    cursor_n = 2'd0;

    one_held   = i_btn_up ^ i_btn_down;
    btn_edge   = (i_btn_up && !up_prev) || (i_btn_down && !dn_prev);
    repeat_hit = one_held && (hold_q == RW'(REPEAT_DLY - 1));

    if (state == IDLE) begin
      if (i_btn_mode) begin
        hour_n  = i_hour;
        min_n   = i_min;
        sec_n   = i_sec;
        state_n = SET_HOUR;
        fresh   = 1'b1;
      end
    end else if (i_btn_mode) begin
      state_n = IDLE;
      load_n  = 1'b1;
    end else if (i_btn_sel) begin
      case (state)
        SET_HOUR: state_n = SET_MIN;
        SET_MIN:  state_n = SET_SEC;
        default:  state_n = SET_HOUR;
      endcase
      hold_n = '0;
      fresh  = 1'b1;
      to_n   = '0;
    end else begin
      // After a repeat step the counter reloads to REPEAT_DLY-REPEAT_PER, so
      // the same terminal compare yields every later step REPEAT_PER apart.
      if (!one_held) begin
        hold_n = '0;
      end else if (btn_edge) begin
        hold_n  = RW'(1);
        step_up = i_btn_up;
        step_dn = i_btn_down;
      end else if (repeat_hit) begin
        hold_n  = RW'(REPEAT_DLY - REPEAT_PER);
        step_up = i_btn_up;
        step_dn = i_btn_down;
      end else begin
        hold_n = hold_q + 1'b1;
      end

      if (step_up || step_dn) begin
        fresh = 1'b1;
        to_n  = '0;
        case (state)
          SET_HOUR: begin
            if (step_up) hour_n = (o_hour == HW'(HOUR_MAX - 1)) ? '0 : o_hour + 1'b1;
            else         hour_n = (o_hour == '0) ? HW'(HOUR_MAX - 1) : o_hour - 1'b1;
          end
          SET_MIN: begin
            if (step_up) min_n = (o_min == MW'(MIN_MAX - 1)) ? '0 : o_min + 1'b1;
            else         min_n = (o_min == '0) ? MW'(MIN_MAX - 1) : o_min - 1'b1;
          end
          default: begin
            if (step_up) sec_n = (o_sec == SW'(SEC_MAX - 1)) ? '0 : o_sec + 1'b1;
            else         sec_n = (o_sec == '0) ? SW'(SEC_MAX - 1) : o_sec - 1'b1;
          end
        endcase
      end else if (to_q == TW'(TIMEOUT - 1)) begin
        state_n = IDLE;
      end else begin
        to_n = to_q + 1'b1;
      end
    end

    if (state_n == IDLE) begin
      hold_n  = '0;
      to_n    = '0;
      bcnt_n  = '0;
      blink_n = 1'b0;
    end else if (fresh) begin
      bcnt_n  = '0;
      blink_n = 1'b1;
    end else if (bcnt_q == BW'(BLINK_PER - 1)) begin
      bcnt_n  = '0;
      blink_n = ~o_blink;
    end else begin
      bcnt_n = bcnt_q + 1'b1;
    end

    case (state_n)
      SET_MIN: cursor_n = 2'd1;
      SET_SEC: cursor_n = 2'd2;
      default: cursor_n = 2'd0;
    endcase
  end

  // State, shadow and output registers; reset discards any edit in progress
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      o_hour     <= '0;
      o_min      <= '0;
      o_sec      <= '0;
      o_load     <= 1'b0;
      o_set_mode <= 1'b0;
      o_cursor   <= 2'd0;
      o_blink    <= 1'b0;
      hold_q     <= '0;
      bcnt_q     <= '0;
      to_q       <= '0;
      up_prev    <= 1'b0;
      dn_prev    <= 1'b0;
    end else begin
      state      <= state_n;
      o_hour     <= hour_n;
      o_min      <= min_n;
      o_sec      <= sec_n;
      o_load     <= load_n;
      o_set_mode <= (state_n != IDLE);
      o_cursor   <= cursor_n;
      o_blink    <= blink_n;
      hold_q     <= hold_n;
      bcnt_q     <= bcnt_n;
      to_q       <= to_n;
      up_prev    <= i_btn_up;
      dn_prev    <= i_btn_down;
    end
  end

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: table vectors, directed corner sequences and a randomized
// run against a cycle-level behavioural model of the time-set controller.
module tb_time_set_ctrl;

  localparam int unsigned DLY = 8;
  localparam int unsigned PER = 4;
  localparam int unsigned BLK = 3;
  localparam int unsigned TMO = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       i_btn_mode = 1'b0, i_btn_sel = 1'b0, i_btn_up = 1'b0, i_btn_down = 1'b0;
  logic [4:0] i_hour = '0;
  logic [5:0] i_min = '0, i_sec = '0;
  logic       o_set_mode, o_load, o_blink;
  logic [4:0] o_hour;
  logic [5:0] o_min, o_sec;
  logic [1:0] o_cursor;

  int total = 0;
  int bad   = 0;

  time_set_ctrl #(
    .HOUR_MAX(24), .MIN_MAX(60), .SEC_MAX(60),
    .REPEAT_DLY(DLY), .REPEAT_PER(PER), .BLINK_PER(BLK), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .i_btn_mode(i_btn_mode), .i_btn_sel(i_btn_sel),
    .i_btn_up(i_btn_up), .i_btn_down(i_btn_down),
    .i_hour(i_hour), .i_min(i_min), .i_sec(i_sec),
    .o_set_mode(o_set_mode), .o_load(o_load),
    .o_hour(o_hour), .o_min(o_min), .o_sec(o_sec),
    .o_cursor(o_cursor), .o_blink(o_blink)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int m_field;      // -1 when not editing, else 0/1/2 = hour/min/sec
  int m_val[3];
  int m_mod[3];
  bit m_load, m_prev_up, m_prev_dn;
  int m_run;        // consecutive single-button held cycles
  int m_quiet;      // set-state cycles without an accepted event
  int m_since;      // cycles since entry / field change / step

  task automatic model_reset();
    m_field = -1;
    m_val[0] = 0; m_val[1] = 0; m_val[2] = 0;
    m_mod[0] = 24; m_mod[1] = 60; m_mod[2] = 60;
    m_load = 0; m_prev_up = 0; m_prev_dn = 0;
    m_run = 0; m_quiet = 0; m_since = 0;
  endtask

  task automatic model_clock(bit md, bit sl, bit up, bit dn, int h, int mi, int s);
    bit fresh = 0;
    bit step  = 0;
    bit one   = up ^ dn;
    m_load = 0;
    if (m_field < 0) begin
      if (md) begin
        m_val[0] = h; m_val[1] = mi; m_val[2] = s;
        m_field = 0; fresh = 1; m_quiet = 0;
      end
      m_run = 0;
    end else if (md) begin
      m_field = -1; m_load = 1;
    end else if (sl) begin
      m_field = (m_field + 1) % 3; fresh = 1; m_run = 0; m_quiet = 0;
    end else begin
      if (!one) m_run = 0;
      else if ((up && !m_prev_up) || (dn && !m_prev_dn)) begin
        m_run = 1; step = 1;
      end else begin
        m_run++;
        if (m_run >= int'(DLY) && (m_run - int'(DLY)) % int'(PER) == 0) step = 1;
      end
      if (step) begin
        m_val[m_field] = (m_val[m_field] + (up ? 1 : -1) + m_mod[m_field]) % m_mod[m_field];
        fresh = 1; m_quiet = 0;
      end else begin
        m_quiet++;
        if (m_quiet == int'(TMO)) m_field = -1;
      end
    end
    if (m_field < 0) begin m_run = 0; m_since = 0; end
    else if (fresh) m_since = 0;
    else m_since++;
    m_prev_up = up; m_prev_dn = dn;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(string tag, string what, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s.%s actual=%0d expected=%0d at %0t", tag, what, act, exp, $time);
    end
  endtask

  task automatic check_model(string tag);
    int eb;
    eb = (m_field < 0) ? 0 : (((m_since / int'(BLK)) % 2 == 0) ? 1 : 0);
    chk(tag, "set_mode", int'(o_set_mode), (m_field >= 0) ? 1 : 0);
    chk(tag, "load", int'(o_load), int'(m_load));
    chk(tag, "hour", int'(o_hour), m_val[0]);
    chk(tag, "min", int'(o_min), m_val[1]);
    chk(tag, "sec", int'(o_sec), m_val[2]);
    chk(tag, "cursor", int'(o_cursor), (m_field < 0) ? 0 : m_field);
    chk(tag, "blink", int'(o_blink), eb);
  endtask

  // Drive one cycle of buttons, advance the model on the edge, sample at negedge
  task automatic cyc(bit md, bit sl, bit up, bit dn);
    i_btn_mode = md; i_btn_sel = sl; i_btn_up = up; i_btn_down = dn;
    @(posedge clk);
    model_clock(md, sl, up, dn, int'(i_hour), int'(i_min), int'(i_sec));
    @(negedge clk);
  endtask

  task automatic do_reset();
    i_btn_mode = 0; i_btn_sel = 0; i_btn_up = 0; i_btn_down = 0;
    reset = 0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    reset = 1;
  endtask

  typedef struct {
    bit md, sl, up, dn;
    bit e_mode, e_load;
    int e_h, e_m, e_s, e_cur;
    bit e_blink;
  } vec_t;

  vec_t vt[11];
  bit   blink_exp[7];
  bit   load_seen;
  bit   up_lvl, dn_lvl;

  initial begin
    vt[0]  = '{0,0,0,0, 0,0,  0,  0,  0, 0, 0};
    vt[1]  = '{1,0,0,0, 1,0, 23, 59, 58, 0, 1};
    vt[2]  = '{0,0,1,0, 1,0,  0, 59, 58, 0, 1};
    vt[3]  = '{0,0,0,0, 1,0,  0, 59, 58, 0, 1};
    vt[4]  = '{0,1,0,0, 1,0,  0, 59, 58, 1, 1};
    vt[5]  = '{0,0,0,1, 1,0,  0, 58, 58, 1, 1};
    vt[6]  = '{0,0,0,0, 1,0,  0, 58, 58, 1, 1};
    vt[7]  = '{1,0,0,0, 0,1,  0, 58, 58, 0, 0};
    vt[8]  = '{0,0,0,0, 0,0,  0, 58, 58, 0, 0};
    vt[9]  = '{0,0,1,0, 0,0,  0, 58, 58, 0, 0};
    vt[10] = '{0,0,0,0, 0,0,  0, 58, 58, 0, 0};
    blink_exp[0] = 1; blink_exp[1] = 1; blink_exp[2] = 1;
    blink_exp[3] = 0; blink_exp[4] = 0; blink_exp[5] = 0; blink_exp[6] = 1;
    model_reset();

    // Reset state while reset is held low
    @(negedge clk);
    chk("rst", "set_mode", int'(o_set_mode), 0);
    chk("rst", "load", int'(o_load), 0);
    chk("rst", "hour", int'(o_hour), 0);
    chk("rst", "cursor", int'(o_cursor), 0);
    chk("rst", "blink", int'(o_blink), 0);

    // Table: wrap on up, wrap-free down, commit with load, idle ignores up
    do_reset();
    i_hour = 5'd23; i_min = 6'd59; i_sec = 6'd58;
    for (int i = 0; i < 11; i++) begin
      cyc(vt[i].md, vt[i].sl, vt[i].up, vt[i].dn);
      chk($sformatf("vec%0d", i), "set_mode", int'(o_set_mode), int'(vt[i].e_mode));
      chk($sformatf("vec%0d", i), "load", int'(o_load), int'(vt[i].e_load));
      chk($sformatf("vec%0d", i), "hour", int'(o_hour), vt[i].e_h);
      chk($sformatf("vec%0d", i), "min", int'(o_min), vt[i].e_m);
      chk($sformatf("vec%0d", i), "sec", int'(o_sec), vt[i].e_s);
      chk($sformatf("vec%0d", i), "cursor", int'(o_cursor), vt[i].e_cur);
      chk($sformatf("vec%0d", i), "blink", int'(o_blink), int'(vt[i].e_blink));
    end

    // Auto-repeat down in SET_SEC starting at 0
    do_reset();
    i_hour = 5'd5; i_min = 6'd10; i_sec = 6'd0;
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    chk("rep", "cursor", int'(o_cursor), 2);
    for (int i = 1; i <= 20; i++) begin
      cyc(0, 0, 0, 1);
      check_model("rep");
      if (i == 1)  chk("rep1", "sec", int'(o_sec), 59);
      if (i == 7)  chk("rep7", "sec", int'(o_sec), 59);
      if (i == 8)  chk("rep8", "sec", int'(o_sec), 58);
      if (i == 20) chk("rep20", "sec", int'(o_sec), 55);
    end
    cyc(0, 0, 0, 0);

    // Both buttons held in SET_MIN, then mode+sel together commits
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 1, 1);
      check_model("both");
    end
    chk("both", "min", int'(o_min), 10);
    chk("both", "sec", int'(o_sec), 55);
    cyc(0, 0, 0, 0);
    cyc(1, 1, 0, 0);
    chk("modesel", "load", int'(o_load), 1);
    chk("modesel", "set_mode", int'(o_set_mode), 0);
    chk("modesel", "hour", int'(o_hour), 5);
    chk("modesel", "min", int'(o_min), 10);
    chk("modesel", "sec", int'(o_sec), 55);
    cyc(0, 0, 0, 0);
    chk("modesel+1", "load", int'(o_load), 0);

    // Timeout: no buttons after entry
    cyc(1, 0, 0, 0);
    load_seen = 0;
    for (int i = 0; i < 49; i++) begin
      cyc(0, 0, 0, 0);
      load_seen = load_seen | o_load;
    end
    chk("tmo49", "set_mode", int'(o_set_mode), 1);
    cyc(0, 0, 0, 0);
    load_seen = load_seen | o_load;
    chk("tmo50", "set_mode", int'(o_set_mode), 0);
    chk("tmo50", "load_seen", int'(load_seen), 0);
    check_model("tmo");
    cyc(0, 0, 0, 0);
    chk("tmo51", "load", int'(o_load), 0);

    // Blink cadence in SET_HOUR, restart on sel
    do_reset();
    cyc(1, 0, 0, 0);
    chk("blink0", "blink", int'(o_blink), int'(blink_exp[0]));
    for (int i = 1; i < 7; i++) begin
      cyc(0, 0, 0, 0);
      chk($sformatf("blink%0d", i), "blink", int'(o_blink), int'(blink_exp[i]));
    end
    cyc(0, 1, 0, 0);
    chk("blinksel", "blink", int'(o_blink), 1);
    for (int i = 1; i < 4; i++) begin
      cyc(0, 0, 0, 0);
      chk($sformatf("blinksel%0d", i), "blink", int'(o_blink), int'(blink_exp[i]));
    end

    // Reset mid-repeat in SET_HOUR, released with up still held
    do_reset();
    i_hour = 5'd7;
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0);
    chk("prerst", "hour", int'(o_hour), 9);
    #2 reset = 0;
    #1;
    model_reset();
    chk("async", "set_mode", int'(o_set_mode), 0);
    chk("async", "hour", int'(o_hour), 0);
    chk("async", "blink", int'(o_blink), 0);
    chk("async", "cursor", int'(o_cursor), 0);
    chk("async", "load", int'(o_load), 0);
    @(negedge clk);
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 0);
      check_model("rstrel");
    end
    chk("rstrel", "hour", int'(o_hour), 0);
    cyc(0, 0, 0, 0);

    // Randomized run against the model
    do_reset();
    up_lvl = 0; dn_lvl = 0;
    for (int i = 0; i < 3000; i++) begin
      i_hour = 5'($urandom_range(0, 23));
      i_min  = 6'($urandom_range(0, 59));
      i_sec  = 6'($urandom_range(0, 59));
      if ($urandom_range(0, 5) == 0) up_lvl = ~up_lvl;
      if ($urandom_range(0, 5) == 0) dn_lvl = ~dn_lvl;
      cyc($urandom_range(0, 24) == 0, $urandom_range(0, 11) == 0, up_lvl, dn_lvl);
      check_model("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
